// File: rtl/mips_defs.sv
`default_nettype none
// mips_defs: opcode values, state encodings, mux-select codes and fault codes
// shared by the multicycle MIPS controller and its sub-modules.
package mips_defs;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage : mips_defs
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// mem_wait_timer: 4-bit wait-cycle counter for memory handshakes; expired_o flags
// the wait cycle that would bring the count up to LIMIT.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic expired_o
);

    localparam logic [3:0] LIMIT_M1 = 4'(LIMIT - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 4'd0;
        end else if (cnt_en_i) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = cnt_en_i && (count_q == LIMIT_M1);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/mips_dff.sv
`default_nettype none
// mips_dff: parameterised D flip-flop with enable and asynchronous active-low reset.
module mips_dff #(
    parameter int unsigned            WIDTH   = 1,
    parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RST_VAL;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule : mips_dff
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// multicycle_ctrl: Moore controller for the multicycle MIPS datapath with a
// bounded memory handshake and illegal-opcode / timeout fault reporting.
module multicycle_ctrl
    import mips_defs::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AEn,
    output logic       ALUOutEn,
    output logic       MDREn,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Fault,
    output logic [1:0] FaultCode,
    output logic [3:0] State
);

    logic [3:0] state_raw_q;
    state_e     state_q;
    state_e     state_d;
    logic [1:0] fault_code_q;
    logic [1:0] fault_code_d;
    logic       w_in_wait;
    logic       w_expired;
    // Branch qualification with Zero happens in the datapath, not here.
    logic       unused_zero;

    assign unused_zero = Zero;
    assign state_q     = state_e'(state_raw_q);
    assign w_in_wait   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    mips_dff #(
        .WIDTH   (4),
        .RST_VAL (4'(S_IDLE))
    ) u_state_reg (
        .clk_i  (CLK),
        .rst_ni (Reset),
        .en_i   (1'b1),
        .d_i    (state_d),
        .q_o    (state_raw_q)
    );

    mips_dff #(
        .WIDTH   (2),
        .RST_VAL (FAULT_NONE)
    ) u_fault_code_reg (
        .clk_i  (CLK),
        .rst_ni (Reset),
        .en_i   (1'b1),
        .d_i    (fault_code_d),
        .q_o    (fault_code_q)
    );

    // Leaving the wait state (ready or timeout) clears the count for the next entry.
    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i     (CLK),
        .rst_ni    (Reset),
        .clr_i     (!w_in_wait || MemReady || w_expired),
        .cnt_en_i  (w_in_wait && !MemReady),
        .expired_o (w_expired)
    );

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = MemReady ? S_DECODE : (w_expired ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (Opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEMRD:  state_d = MemReady ? S_MEMWB : (w_expired ? S_TRAP : S_MEMRD);
            S_MEMWR:  state_d = MemReady ? S_FETCH : (w_expired ? S_TRAP : S_MEMWR);
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB, S_TRAP: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Decode-stage entries into TRAP are illegal opcodes; all others are memory timeouts.
    always_comb begin
        fault_code_d = fault_code_q;
        if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
            fault_code_d = ((state_q == S_DECODE) || (state_q == S_MEMADR)) ? FAULT_ILLEGAL
                                                                             : FAULT_TIMEOUT;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        AEn         = 1'b0;
        ALUOutEn    = 1'b0;
        MDREn       = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        Fault       = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB  = SRCB_IMM_SH;
                AEn      = 1'b1;
                ALUOutEn = 1'b1;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                ALUOutEn = 1'b1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                MDREn   = MemReady;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_FUNCT;
                ALUOutEn = 1'b1;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_TRAP: begin
                Fault = 1'b1;
            end
            default: begin
                Fault = 1'b0;
            end
        endcase
    end

    assign FaultCode = fault_code_q;
    assign State     = state_raw_q;

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// tb_multicycle_ctrl: directed, self-checking bench for the multicycle MIPS controller.
module tb_multicycle_ctrl;

    logic       CLK;
    logic       Reset;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic       IRWrite, AEn, ALUOutEn, MDREn;
    logic       RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       Fault;
    logic [1:0] FaultCode;
    logic [3:0] State;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .Zero        (Zero),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .AEn         (AEn),
        .ALUOutEn    (ALUOutEn),
        .MDREn       (MDREn),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .Fault       (Fault),
        .FaultCode   (FaultCode),
        .State       (State)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite}_{IRWrite,AEn,ALUOutEn,MDREn}_
    // {RegWrite,RegDst,MemtoReg,ALUSrcA}_{ALUSrcB,ALUOp}_{PCSource,Fault}
    logic [19:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                   IRWrite, AEn, ALUOutEn, MDREn,
                   RegWrite, RegDst, MemtoReg, ALUSrcA,
                   ALUSrcB, ALUOp, PCSource, Fault};

    localparam logic [19:0] C_IDLE    = 20'b00000_0000_0000_0000_000;
    localparam logic [19:0] C_FET_RDY = 20'b10010_1000_0000_0100_000;
    localparam logic [19:0] C_FET_NR  = 20'b00010_0000_0000_0100_000;
    localparam logic [19:0] C_DECODE  = 20'b00000_0110_0000_1100_000;
    localparam logic [19:0] C_MEMADR  = 20'b00000_0010_0001_1000_000;
    localparam logic [19:0] C_RD_RDY  = 20'b00110_0001_0000_0000_000;
    localparam logic [19:0] C_RD_NR   = 20'b00110_0000_0000_0000_000;
    localparam logic [19:0] C_MEMWR   = 20'b00101_0000_0000_0000_000;
    localparam logic [19:0] C_MEMWB   = 20'b00000_0000_1010_0000_000;
    localparam logic [19:0] C_EXEC    = 20'b00000_0010_0001_0010_000;
    localparam logic [19:0] C_ALUWB   = 20'b00000_0000_1100_0000_000;
    localparam logic [19:0] C_BRANCH  = 20'b01000_0000_0001_0001_010;
    localparam logic [19:0] C_JUMP    = 20'b10000_0000_0000_0000_100;
    localparam logic [19:0] C_ADDIWB  = 20'b00000_0000_1000_0000_000;
    localparam logic [19:0] C_TRAP    = 20'b00000_0000_0000_0000_001;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Settle, compare State and the control vector, then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] exp_state, input logic [19:0] exp_ctrl);
        #1;
        check({tag, ".state"}, 32'(State), 32'(exp_state));
        check({tag, ".ctrl"}, 32'(ctrl), 32'(exp_ctrl));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset    = 1'b0;
        Opcode   = 6'h00;
        Zero     = 1'b0;
        MemReady = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset.state", 32'(State), 32'd0);
        check("reset.ctrl", 32'(ctrl), 32'(C_IDLE));
        check("reset.fcode", 32'(FaultCode), 32'd0);
        Reset = 1'b1;
        cyc("idle", 4'd0, C_IDLE);

        // R-type, zero-wait memory: 1,2,7,8 then back to FETCH
        MemReady = 1'b1;
        Opcode   = 6'h00;
        cyc("r.fetch", 4'd1, C_FET_RDY);
        cyc("r.decode", 4'd2, C_DECODE);
        cyc("r.exec", 4'd7, C_EXEC);
        cyc("r.aluwb", 4'd8, C_ALUWB);

        // LW with three not-ready cycles in MEMRD
        Opcode = 6'h23;
        cyc("lw.fetch", 4'd1, C_FET_RDY);
        cyc("lw.decode", 4'd2, C_DECODE);
        cyc("lw.memadr", 4'd3, C_MEMADR);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw.memrd_wait", 4'd4, C_RD_NR);
        MemReady = 1'b1;
        cyc("lw.memrd_rdy", 4'd4, C_RD_RDY);
        cyc("lw.memwb", 4'd5, C_MEMWB);

        // SW zero-wait
        Opcode = 6'h2B;
        cyc("sw.fetch", 4'd1, C_FET_RDY);
        cyc("sw.decode", 4'd2, C_DECODE);
        cyc("sw.memadr", 4'd3, C_MEMADR);
        cyc("sw.memwr", 4'd6, C_MEMWR);

        // BEQ taken then not taken: controller output independent of Zero
        Opcode = 6'h04;
        Zero   = 1'b1;
        cyc("beq1.fetch", 4'd1, C_FET_RDY);
        cyc("beq1.decode", 4'd2, C_DECODE);
        cyc("beq1.branch", 4'd9, C_BRANCH);
        Zero = 1'b0;
        cyc("beq0.fetch", 4'd1, C_FET_RDY);
        cyc("beq0.decode", 4'd2, C_DECODE);
        cyc("beq0.branch", 4'd9, C_BRANCH);

        // J
        Opcode = 6'h02;
        cyc("j.fetch", 4'd1, C_FET_RDY);
        cyc("j.decode", 4'd2, C_DECODE);
        cyc("j.jump", 4'd10, C_JUMP);

        // ADDI
        Opcode = 6'h08;
        cyc("addi.fetch", 4'd1, C_FET_RDY);
        cyc("addi.decode", 4'd2, C_DECODE);
        cyc("addi.ex", 4'd11, C_MEMADR);
        cyc("addi.wb", 4'd12, C_ADDIWB);

        // Illegal opcode -> TRAP with code 01, one-cycle Fault
        Opcode = 6'h3F;
        cyc("ill.fetch", 4'd1, C_FET_RDY);
        cyc("ill.decode", 4'd2, C_DECODE);
        check("ill.fcode", 32'(FaultCode), 32'd1);
        cyc("ill.trap", 4'd13, C_TRAP);
        check("ill.fcode_held", 32'(FaultCode), 32'd1);

        // Fetch timeout: 15 not-ready cycles, then TRAP code 10
        Opcode   = 6'h00;
        MemReady = 1'b0;
        for (int i = 0; i < 15; i++) cyc("to.fetch_wait", 4'd1, C_FET_NR);
        check("to.fcode", 32'(FaultCode), 32'd2);
        cyc("to.trap", 4'd13, C_TRAP);

        // Ready arrives on the 15th wait cycle: completes, no fault
        for (int i = 0; i < 14; i++) cyc("lim.fetch_wait", 4'd1, C_FET_NR);
        MemReady = 1'b1;
        cyc("lim.fetch_rdy", 4'd1, C_FET_RDY);
        cyc("lim.decode", 4'd2, C_DECODE);
        cyc("lim.exec", 4'd7, C_EXEC);
        check("lim.fcode_held", 32'(FaultCode), 32'd2);
        cyc("lim.aluwb", 4'd8, C_ALUWB);

        // Asynchronous reset in the middle of MEMRD
        Opcode = 6'h23;
        cyc("ar.fetch", 4'd1, C_FET_RDY);
        cyc("ar.decode", 4'd2, C_DECODE);
        cyc("ar.memadr", 4'd3, C_MEMADR);
        MemReady = 1'b0;
        #1;
        check("ar.memrd", 32'(State), 32'd4);
        #2;
        Reset = 1'b0;
        #1;
        check("ar.state", 32'(State), 32'd0);
        check("ar.ctrl", 32'(ctrl), 32'(C_IDLE));
        check("ar.fcode", 32'(FaultCode), 32'd0);
        @(posedge CLK);
        #1;
        check("ar.hold", 32'(State), 32'd0);
        Reset = 1'b1;
        cyc("ar.idle", 4'd0, C_IDLE);
        cyc("ar.fetch2", 4'd1, C_FET_NR);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multicycle_ctrl
`default_nettype wire
